mc_alu_unit: RTL and testbench

MC_ALU_UNIT -- requirements
Module: mc_alu_unit

---
 rtl/mc_alu_unit_if.sv | 24 ++
 rtl/mc_alu_unit.sv | 150 +++++++++++++++
 tb/tb_mc_alu_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mc_alu_unit_if.sv
// Request/response bundle between an ALU requester and mc_alu_unit.
// The requester drives operands, flush and out_ready; the unit drives the handshake status and the result.
interface mc_alu_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  modport master (
    output in_valid, Operation, SrcA, SrcB, flush, out_ready,
    input  in_ready, out_valid, ALUResult, Zero
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, flush, out_ready,
    output in_ready, out_valid, ALUResult, Zero
  );
endinterface

// File: rtl/mc_alu_unit.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops, plus bit-serial shifts (one bit per cycle).
// Valid/ready handshake on both sides; flush aborts whatever operation is in flight.
module mc_alu_unit (
  input  logic          clk,
  input  logic          rst_n,
  mc_alu_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SUB = 4'b0110, OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000, OP_NE  = 4'b1001, OP_GE  = 4'b1010, OP_LT  = 4'b1100;

  state_t      state_r, state_nxt_s;
  logic [4:0]  cnt_r;
  logic [31:0] work_r, result_r;
  logic [3:0]  op_r;
  logic        in_ready_s, accept_s, is_shift_s, load_res_s, load_shift_s, step_s, finish_s;
  logic [31:0] eval_s, step_val_s;

  // One-bit step of the serial shifter; SRA replicates the sign bit.
  function automatic logic [31:0] shift_one(input logic [3:0] op, input logic [31:0] v);
    case (op)
      OP_SLL:  shift_one = {v[30:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, v[31:1]};
      OP_SRA:  shift_one = {v[31], v[31:1]};
      default: shift_one = v;
    endcase
  endfunction

  // Shift ops only reach here with amount 0, so they pass SrcA through unchanged.
  function automatic logic [31:0] alu_eval(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_AND:  alu_eval = a & b;
      OP_OR:   alu_eval = a | b;
      OP_ADD:  alu_eval = a + b;
      OP_XOR:  alu_eval = a ^ b;
      OP_SUB:  alu_eval = a - b;
      OP_SLL, OP_SRL, OP_SRA: alu_eval = a;
      OP_EQ:   alu_eval = {31'd0, (a == b)};
      OP_NE:   alu_eval = {31'd0, (a != b)};
      OP_GE:   alu_eval = {31'd0, ($signed(a) >= $signed(b))};
      OP_LT:   alu_eval = {31'd0, ($signed(a) <  $signed(b))};
      default: alu_eval = 32'd0;
    endcase
  endfunction

  assign is_shift_s = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) || (bus.Operation == OP_SRA);
  assign eval_s     = alu_eval(bus.Operation, bus.SrcA, bus.SrcB);
  assign step_val_s = shift_one(op_r, work_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush wins over every other transition.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.flush) begin
          state_nxt_s = IDLE;
        end else if (accept_s) begin
          state_nxt_s = (is_shift_s && (bus.SrcB[4:0] != 5'd0)) ? SHIFT : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (bus.flush) begin
          state_nxt_s = IDLE;
        end else if (cnt_r <= 5'd1) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (bus.flush || bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs and datapath strobes decoded from the current state.
  always_comb begin
    in_ready_s   = (state_r == IDLE) && rst_n;
    accept_s     = bus.in_valid && in_ready_s;
    load_res_s   = 1'b0;
    load_shift_s = 1'b0;
    step_s       = 1'b0;
    if (accept_s && !bus.flush) begin
      load_shift_s = is_shift_s && (bus.SrcB[4:0] != 5'd0);
      load_res_s   = !load_shift_s;
    end else begin
      load_shift_s = 1'b0;
      load_res_s   = 1'b0;
    end
    if ((state_r == SHIFT) && !bus.flush) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
    finish_s = step_s && (cnt_r <= 5'd1);
  end

  // Datapath: operand capture, serial shifting and the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 32'd0;
      work_r   <= 32'd0;
      cnt_r    <= 5'd0;
      op_r     <= 4'd0;
    end else begin
      if (load_res_s) begin
        result_r <= eval_s;
      end else if (finish_s) begin
        result_r <= step_val_s;
      end else begin
        result_r <= result_r;
      end
      if (load_shift_s) begin
        work_r <= bus.SrcA;
        cnt_r  <= bus.SrcB[4:0];
        op_r   <= bus.Operation;
      end else if (step_s) begin
        work_r <= step_val_s;
        cnt_r  <= cnt_r - 5'd1;
      end else if (bus.flush) begin
        cnt_r  <= 5'd0;
      end else begin
        work_r <= work_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == DONE);
  assign bus.ALUResult = result_r;
  assign bus.Zero      = (result_r == 32'd0);
endmodule

// File: tb/tb_mc_alu_unit.sv
// Directed bench for mc_alu_unit: hand-computed vectors, latency, backpressure, flush and reset checks.
module tb_mc_alu_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_last;
  int          seen;

  mc_alu_unit_if bus();

  mc_alu_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op, garble inputs after accept, measure latency, optionally hold out_ready low.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, ".rdy"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.SrcA      = $urandom;
    bus.SrcB      = $urandom;
    bus.Operation = 4'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 80) begin
      chk({tag, ".busy"}, {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, bus.ALUResult, exp_res);
    chk({tag, ".zero"}, {31'd0, bus.Zero}, {31'd0, (exp_res == 32'd0)});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_v"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, ".hold_r"}, bus.ALUResult, exp_res);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".post_v"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, ".post_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    exp_last = exp_res;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.Operation = 4'd0; bus.SrcA = 32'd0; bus.SrcB = 32'd0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    #12;
    chk("rst.rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("rst.vld", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.res", bus.ALUResult, 32'd0);
    chk("rst.zero", {31'd0, bus.Zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
    run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, 0);
    run_op("or",  4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1, 0);
    run_op("xor", 4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1, 0);
    run_op("sra4", 4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, 0);
    run_op("sll5", 4'b0100, 32'h0000_0003, 32'd5, 32'h0000_0060, 6, 0);
    run_op("sll_b36", 4'b0100, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 5, 0);
    run_op("srl31", 4'b0101, 32'h8000_0001, 32'd31, 32'h0000_0001, 32, 0);
    run_op("srl0", 4'b0101, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 0);
    run_op("eq", 4'b1000, 32'd7, 32'd7, 32'd1, 1, 0);
    run_op("ne", 4'b1001, 32'd7, 32'd7, 32'd0, 1, 0);
    run_op("lt", 4'b1100, 32'hFFFF_FFFE, 32'd3, 32'd1, 1, 0);
    run_op("ge", 4'b1010, 32'hFFFF_FFFE, 32'd3, 32'd0, 1, 0);
    run_op("ge_pos", 4'b1010, 32'd3, 32'hFFFF_FFFE, 32'd1, 1, 0);
    run_op("op1111", 4'b1111, 32'd5, 32'd5, 32'd0, 1, 0);
    run_op("op1011", 4'b1011, 32'h1234_5678, 32'd9, 32'd0, 1, 0);
    run_op("sub_bp", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 3);

    // Flush in the third shift cycle.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.Operation = 4'b0100; bus.SrcA = 32'd1; bus.SrcB = 32'd31;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush.vld", {31'd0, bus.out_valid}, 32'd0);
    chk("flush.rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("flush.res", bus.ALUResult, exp_last);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("flush.never", seen, 0);

    // Flush together with a request accepts nothing.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.Operation = 4'b0010; bus.SrcA = 32'd1; bus.SrcB = 32'd1; bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("flacc.rdy", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("flacc.never", seen, 0);
    chk("flacc.res", bus.ALUResult, exp_last);

    // Asynchronous reset in the middle of a long shift.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.Operation = 4'b0100; bus.SrcA = 32'd1; bus.SrcB = 32'd31;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("arst.vld", {31'd0, bus.out_valid}, 32'd0);
    chk("arst.res", bus.ALUResult, 32'd0);
    chk("arst.zero", {31'd0, bus.Zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst.rel_rdy", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("arst.never", seen, 0);
    run_op("add_after", 4'b0010, 32'd2, 32'd3, 32'd5, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
